dcache_responder: RTL and testbench

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dcache_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// Data-cache responder: turns one execute-stage memory request into at most
// one outstanding memory transaction and returns a single-cycle response.
module dcache_responder (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  input  logic        req_kill_i,
  input  logic [63:0] req_rs1_i,
  input  logic [63:0] req_rs2_i,
  input  logic [63:0] req_imm_i,
  input  logic [6:0]  req_instr_type_i,
  input  logic [2:0]  req_size_i,
  output logic        resp_valid_o,
  output logic        resp_lock_o,
  output logic [63:0] resp_data_o,
  output logic [63:0] resp_addr_o,
  output logic        resp_xcpt_ma_st_o,
  output logic        resp_xcpt_ma_ld_o,
  output logic        resp_xcpt_flt_st_o,
  output logic        resp_xcpt_flt_ld_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [39:0] mem_req_addr_o,
  output logic        mem_req_we_o,
  output logic [63:0] mem_req_wdata_o,
  output logic [7:0]  mem_req_be_o,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_resp_data_i,
  input  logic        mem_resp_error_i
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [63:0] ea;
  logic        is_store, is_amo, misaligned, accept, capture;
  logic [7:0]  be_mask;
  logic [63:0] wdata_rep, ld_sh, ld_ext;
  logic [63:0] cap_data, cap_addr;
  logic        cap_err, cap_store;

  // Request decode: effective address, type class, alignment, lane data.
  always_comb begin
    ea         = req_rs1_i + req_imm_i;
    is_store   = (req_instr_type_i == 7'd43) || (req_instr_type_i == 7'd46) ||
                 (req_instr_type_i == 7'd49) || (req_instr_type_i == 7'd51);
    is_amo     = (req_instr_type_i >= 7'd53) && (req_instr_type_i <= 7'd74);
    accept     = req_valid_i & ~req_kill_i;
    misaligned = 1'b0;
    be_mask    = 8'h01;
    wdata_rep  = {8{req_rs2_i[7:0]}};
    ld_sh      = mem_resp_data_i >> {ea[2:0], 3'b000};
    ld_ext     = '0;
    case (req_size_i[1:0])
      2'd0: begin
        be_mask   = 8'h01;
        wdata_rep = {8{req_rs2_i[7:0]}};
        ld_ext    = req_size_i[2] ? {56'b0, ld_sh[7:0]} : {{56{ld_sh[7]}}, ld_sh[7:0]};
      end
      2'd1: begin
        misaligned = ea[0];
        be_mask    = 8'h03;
        wdata_rep  = {4{req_rs2_i[15:0]}};
        ld_ext     = req_size_i[2] ? {48'b0, ld_sh[15:0]} : {{48{ld_sh[15]}}, ld_sh[15:0]};
      end
      2'd2: begin
        misaligned = |ea[1:0];
        be_mask    = 8'h0F;
        wdata_rep  = {2{req_rs2_i[31:0]}};
        ld_ext     = req_size_i[2] ? {32'b0, ld_sh[31:0]} : {{32{ld_sh[31]}}, ld_sh[31:0]};
      end
      default: begin
        misaligned = |ea[2:0];
        be_mask    = 8'hFF;
        wdata_rep  = req_rs2_i;
        ld_ext     = ld_sh;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Response capture; only written on the cycle that moves to DONE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cap_data  <= '0;
      cap_addr  <= '0;
      cap_err   <= 1'b0;
      cap_store <= 1'b0;
    end else if (capture) begin
      cap_data  <= ld_ext;
      cap_addr  <= ea;
      cap_err   <= mem_resp_error_i;
      cap_store <= is_store;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt          = state;
    capture            = 1'b0;
    resp_valid_o       = 1'b0;
    resp_lock_o        = 1'b0;
    resp_data_o        = '0;
    resp_addr_o        = '0;
    resp_xcpt_ma_st_o  = 1'b0;
    resp_xcpt_ma_ld_o  = 1'b0;
    resp_xcpt_flt_st_o = 1'b0;
    resp_xcpt_flt_ld_o = 1'b0;
    mem_req_valid_o    = 1'b0;
    mem_req_addr_o     = '0;
    mem_req_we_o       = 1'b0;
    mem_req_wdata_o    = '0;
    mem_req_be_o       = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            resp_valid_o      = 1'b1;
            resp_addr_o       = ea;
            resp_xcpt_ma_st_o = is_store | is_amo;
            resp_xcpt_ma_ld_o = ~(is_store | is_amo);
          end else if (is_amo) begin
            resp_valid_o       = 1'b1;
            resp_addr_o        = ea;
            resp_xcpt_flt_st_o = 1'b1;
          end else begin
            resp_lock_o = 1'b1;
            state_nxt   = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Valid stays up on a kill so a kill coinciding with ready still
        // completes the handshake and is drained; a kill without ready
        // abandons the request before memory ever sees it.
        resp_lock_o     = 1'b1;
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {ea[39:3], 3'b000};
        mem_req_we_o    = is_store;
        mem_req_wdata_o = wdata_rep;
        mem_req_be_o    = be_mask << ea[2:0];
        if (mem_req_ready_i) begin
          if (req_kill_i) begin
            state_nxt = mem_resp_valid_i ? IDLE : DRAIN;
          end else if (mem_resp_valid_i) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end else if (req_kill_i) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        resp_lock_o = 1'b1;
        if (req_kill_i) begin
          // A response arriving with the kill is simply consumed.
          state_nxt = mem_resp_valid_i ? IDLE : DRAIN;
        end else if (mem_resp_valid_i) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        resp_valid_o       = 1'b1;
        resp_addr_o        = cap_addr;
        resp_data_o        = (cap_err | cap_store) ? '0 : cap_data;
        resp_xcpt_flt_ld_o = cap_err & ~cap_store;
        resp_xcpt_flt_st_o = cap_err & cap_store;
        state_nxt          = IDLE;
      end
      DRAIN: begin
        resp_lock_o = accept;
        if (mem_resp_valid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs read zero for as long as reset is held.
    if (!rstn_i) begin
      resp_valid_o       = 1'b0;
      resp_lock_o        = 1'b0;
      resp_data_o        = '0;
      resp_addr_o        = '0;
      resp_xcpt_ma_st_o  = 1'b0;
      resp_xcpt_ma_ld_o  = 1'b0;
      resp_xcpt_flt_st_o = 1'b0;
      resp_xcpt_flt_ld_o = 1'b0;
      mem_req_valid_o    = 1'b0;
      mem_req_addr_o     = '0;
      mem_req_we_o       = 1'b0;
      mem_req_wdata_o    = '0;
      mem_req_be_o       = '0;
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: a table of single-cycle IDLE
// vectors plus hand-written multi-cycle transaction sequences.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_kill;
  logic [63:0] rs1, rs2, imm;
  logic [6:0]  itype;
  logic [2:0]  size;
  logic        resp_valid, resp_lock;
  logic [63:0] resp_data, resp_addr;
  logic        ma_st, ma_ld, flt_st, flt_ld;
  logic        mreq_valid, mreq_ready, mreq_we;
  logic [39:0] mreq_addr;
  logic [63:0] mreq_wdata;
  logic [7:0]  mreq_be;
  logic        mresp_valid, mresp_error;
  logic [63:0] mresp_data;

  int unsigned checks = 0;
  int unsigned passes = 0;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_kill_i(req_kill),
    .req_rs1_i(rs1), .req_rs2_i(rs2), .req_imm_i(imm),
    .req_instr_type_i(itype), .req_size_i(size),
    .resp_valid_o(resp_valid), .resp_lock_o(resp_lock),
    .resp_data_o(resp_data), .resp_addr_o(resp_addr),
    .resp_xcpt_ma_st_o(ma_st), .resp_xcpt_ma_ld_o(ma_ld),
    .resp_xcpt_flt_st_o(flt_st), .resp_xcpt_flt_ld_o(flt_ld),
    .mem_req_valid_o(mreq_valid), .mem_req_ready_i(mreq_ready),
    .mem_req_addr_o(mreq_addr), .mem_req_we_o(mreq_we),
    .mem_req_wdata_o(mreq_wdata), .mem_req_be_o(mreq_be),
    .mem_resp_valid_i(mresp_valid), .mem_resp_data_i(mresp_data),
    .mem_resp_error_i(mresp_error)
  );

  typedef struct {
    string       name;
    logic        valid, kill;
    logic [6:0]  itype;
    logic [2:0]  size;
    logic [63:0] rs1, imm;
    logic [6:0]  flags;  // {resp_valid, lock, ma_ld, ma_st, flt_ld, flt_st, mem_req_valid}
    logic [63:0] addr;
  } vec_t;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic drive(input logic v, input logic [6:0] t, input logic [2:0] s,
                       input logic [63:0] a, input logic [63:0] i, input logic [63:0] d);
    req_valid = v; req_kill = 1'b0; itype = t; size = s; rs1 = a; imm = i; rs2 = d;
  endtask

  function automatic logic [199:0] all_outs();
    return {resp_valid, resp_lock, ma_ld, ma_st, flt_ld, flt_st, mreq_valid, mreq_we,
            mreq_be, mreq_addr, mreq_wdata, resp_data, resp_addr};
  endfunction

  // Full load/store transaction: accept, handshake, response next cycle, DONE.
  task automatic run_txn(input string name, input logic [6:0] t, input logic [2:0] s,
                         input logic [63:0] a, input logic [63:0] i, input logic [63:0] d,
                         input logic [7:0] exp_be, input logic [63:0] mdata, input logic err,
                         input logic [63:0] exp_data, input logic exp_fld, input logic exp_fst,
                         input logic [63:0] exp_addr);
    @(negedge clk); drive(1'b1, t, s, a, i, d); #1;
    chk({name, "_lock"}, resp_lock, 1'b1);
    @(negedge clk); mreq_ready = 1'b1; #1;
    chk({name, "_be"}, {mreq_valid, mreq_be}, {1'b1, exp_be});
    @(negedge clk); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = mdata; mresp_error = err;
    @(negedge clk); mresp_valid = 1'b0; mresp_error = 1'b0; #1;
    chk({name, "_resp"}, {resp_valid, resp_lock, flt_ld, flt_st, resp_addr, resp_data},
        {1'b1, 1'b0, exp_fld, exp_fst, exp_addr, exp_data});
    #1 req_valid = 1'b0;
  endtask

  vec_t vecs[$];
  int   lock_cycles;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_error = 1'b0; mresp_data = '0;
    drive(1'b0, 7'd0, 3'd0, '0, '0, '0);

    // Table of IDLE-cycle vectors; the request is withdrawn before the clock edge.
    vecs.push_back('{"ld_ma",      1, 0, 7'd42, 3'd3, 64'h1000, 64'h4, 7'b1010000, 64'h1004});
    vecs.push_back('{"lh_ma",      1, 0, 7'd44, 3'd1, 64'h2000, 64'h1, 7'b1010000, 64'h2001});
    vecs.push_back('{"sw_ma",      1, 0, 7'd46, 3'd2, 64'h3000, 64'h2, 7'b1001000, 64'h3002});
    vecs.push_back('{"lw_ma",      1, 0, 7'd42, 3'd2, 64'h10,   64'h2, 7'b1010000, 64'h12});
    vecs.push_back('{"sd_wrap_ok", 1, 0, 7'd51, 3'd3, '1,       64'h1, 7'b0100000, 64'h0});
    vecs.push_back('{"amo_w",      1, 0, 7'd60, 3'd2, 64'h100,  64'h0, 7'b1000010, 64'h100});
    vecs.push_back('{"amo_74",     1, 0, 7'd74, 3'd3, 64'h200,  64'h8, 7'b1000010, 64'h208});
    vecs.push_back('{"lb_odd_ok",  1, 0, 7'd42, 3'd0, 64'h7,    64'h0, 7'b0100000, 64'h0});
    vecs.push_back('{"lhu_ok",     1, 0, 7'd52, 3'd5, 64'h1000, 64'h2, 7'b0100000, 64'h0});
    vecs.push_back('{"killed",     1, 1, 7'd42, 3'd3, 64'h1004, 64'h0, 7'b0000000, 64'h0});
    vecs.push_back('{"no_valid",   0, 0, 7'd42, 3'd3, 64'h1004, 64'h0, 7'b0000000, 64'h0});

    #12;
    chk("reset_outs", all_outs(), '0);
    @(negedge clk); rstn = 1'b1; #1;
    chk("idle_outs", all_outs(), '0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].valid, vecs[k].itype, vecs[k].size, vecs[k].rs1, vecs[k].imm, 64'h0);
      req_kill = vecs[k].kill;
      #1;
      chk(vecs[k].name,
          {resp_valid, resp_lock, ma_ld, ma_st, flt_ld, flt_st, mreq_valid, resp_addr, resp_data},
          {vecs[k].flags, vecs[k].addr, 64'h0});
      #1 req_valid = 1'b0; req_kill = 1'b0;
    end

    // LW with response two cycles after ready: lock held four cycles.
    lock_cycles = 0;
    @(negedge clk); drive(1'b1, 7'd42, 3'd2, 64'h1000, 64'h4, '0); #1;
    lock_cycles += int'(resp_lock);
    chk("lw_accept", {resp_valid, mreq_valid}, 2'b00);
    @(negedge clk); mreq_ready = 1'b1; #1;
    lock_cycles += int'(resp_lock);
    chk("lw_issue", {mreq_valid, mreq_we, mreq_be, mreq_addr}, {1'b1, 1'b0, 8'hF0, 40'h1000});
    @(negedge clk); mreq_ready = 1'b0; #1;
    lock_cycles += int'(resp_lock);
    chk("lw_wait_noreq", mreq_valid, 1'b0);
    @(negedge clk); mresp_valid = 1'b1; mresp_data = 64'h8000_0000_0000_0000; #1;
    lock_cycles += int'(resp_lock);
    @(negedge clk); mresp_valid = 1'b0; #1;
    lock_cycles += int'(resp_lock);
    chk("lw_done", {resp_valid, resp_lock, resp_data, resp_addr},
        {1'b1, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'h1004});
    chk("lw_lock_cycles", lock_cycles, 4);
    @(negedge clk); req_valid = 1'b0; #1;
    chk("lw_single_pulse", {resp_valid, resp_lock}, 2'b00);

    // SH at 0x1006 with ack in the handshake cycle; kill in DONE is ignored.
    @(negedge clk); drive(1'b1, 7'd43, 3'd1, 64'h1000, 64'h6, 64'hBEEF); #1;
    chk("sh_accept", resp_lock, 1'b1);
    @(negedge clk); mreq_ready = 1'b1; mresp_valid = 1'b1; #1;
    chk("sh_issue", {mreq_valid, mreq_we, mreq_be, mreq_wdata[63:48]},
        {1'b1, 1'b1, 8'hC0, 16'hBEEF});
    @(negedge clk); mreq_ready = 1'b0; mresp_valid = 1'b0; req_kill = 1'b1; #1;
    chk("sh_done", {resp_valid, resp_lock, flt_st, resp_data, resp_addr},
        {1'b1, 1'b0, 1'b0, 64'h0, 64'h1006});
    #1 req_valid = 1'b0; req_kill = 1'b0;
    @(negedge clk); #1;
    chk("sh_single_pulse", resp_valid, 1'b0);

    // Kill in WAIT, new LBU next cycle: old response dropped, LBU zero-extends.
    @(negedge clk); drive(1'b1, 7'd42, 3'd2, 64'h2000, 64'h0, '0);
    @(negedge clk); mreq_ready = 1'b1;
    @(negedge clk); mreq_ready = 1'b0; req_kill = 1'b1; #1;
    chk("kill_wait_lock", resp_lock, 1'b1);
    @(negedge clk); drive(1'b1, 7'd45, 3'd4, 64'h3000, 64'h3, '0); #1;
    chk("drain_stall", {resp_valid, resp_lock, mreq_valid}, 3'b010);
    @(negedge clk); mresp_valid = 1'b1; mresp_data = 64'h1111_1111_1111_1111; #1;
    chk("drain_drop", {resp_valid, resp_lock}, 2'b01);
    @(negedge clk); mresp_valid = 1'b0; #1;
    chk("lbu_accept", {resp_valid, resp_lock, mreq_valid}, 3'b010);
    @(negedge clk); mreq_ready = 1'b1; #1;
    chk("lbu_issue", {mreq_valid, mreq_we, mreq_be, mreq_addr}, {1'b1, 1'b0, 8'h08, 40'h3000});
    @(negedge clk); mreq_ready = 1'b0; mresp_valid = 1'b1; mresp_data = 64'h0000_0000_FF00_0000;
    @(negedge clk); mresp_valid = 1'b0; #1;
    chk("lbu_done", {resp_valid, resp_data, resp_addr}, {1'b1, 64'hFF, 64'h3003});
    #1 req_valid = 1'b0;

    // Error and extension cases.
    run_txn("sd_err", 7'd43, 3'd3, 64'h4000, 64'h8, 64'h1234, 8'hFF, 64'h0, 1'b1,
            64'h0, 1'b0, 1'b1, 64'h4008);
    run_txn("lb_err", 7'd42, 3'd0, 64'h6000, 64'h0, 64'h0, 8'h01, 64'hFF, 1'b1,
            64'h0, 1'b1, 1'b0, 64'h6000);
    run_txn("lh_sext", 7'd44, 3'd1, 64'h6000, 64'h2, 64'h0, 8'h0C, 64'h0000_0000_8001_0000, 1'b0,
            64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 64'h6002);

    // Kill in ISSUE without ready: back to IDLE, no response.
    @(negedge clk); drive(1'b1, 7'd42, 3'd3, 64'h7000, 64'h0, '0);
    @(negedge clk); req_kill = 1'b1;
    @(negedge clk); req_kill = 1'b0; req_valid = 1'b0; mreq_ready = 1'b1; #1;
    chk("kill_issue_idle", {resp_valid, resp_lock, mreq_valid}, 3'b000);
    @(negedge clk); mreq_ready = 1'b0; #1;
    chk("kill_issue_noresp", resp_valid, 1'b0);

    // Reset mid-ISSUE: outputs zero at once; late response is ignored.
    @(negedge clk); drive(1'b1, 7'd42, 3'd2, 64'h5000, 64'h0, '0);
    @(negedge clk); #1;
    chk("rst_pre_issue", {mreq_valid, resp_lock}, 2'b11);
    #1 rstn = 1'b0; #1;
    chk("rst_mid_issue", all_outs(), '0);
    req_valid = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); mresp_valid = 1'b1; mresp_data = 64'h55; #1;
    chk("rst_late_resp", {resp_valid, resp_lock}, 2'b00);
    @(negedge clk); mresp_valid = 1'b0; #1;
    chk("rst_no_done", resp_valid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
